addsub_core: RTL and testbench
==============================

# addsub_core

Minimal single-issue fetch/execute core holding the program counter, instruction register, 32×32 register file, decode and a two-operation ALU. It supports RISC-V R-type ADD and SUB. It fetches from an external combinational instruction memory, executes one instruction per clock, and writes results back into the register file. It sits between the instruction memory model and the bench/debug logic.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_0000: PC value after reset.
- `PC_STEP`, default 4: PC increment per cycle, in bytes.

Ports (name, direction, width, meaning):
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `imem_addr`, out, 32: fetch address; always equals `pc_value`.
- `imem_rdata`, in, 32: instruction word at `imem_addr`, combinational.
- `pc_value`, out, 32: current PC.
- `instruction`, out, 32: current IR contents.
- `reg_we`, out, 1: writeback enable for the current instruction.
- `alu_result`, out, 32: writeback data for the current instruction.
- `dbg_we`, in, 1: debug register write enable.
- `dbg_addr`, in, 5: debug register index, used for both read and write.
- `dbg_wdata`, in, 32: debug write data.
- `dbg_rdata`, out, 32: asynchronous read of register `dbg_addr`.

## Operation
- Fetch: on every rising edge, `IR <= imem_rdata` and `PC <= PC + PC_STEP`. PC wraps modulo 2^32. There is no stall and no branching.
- Field extraction from IR:
  - opcode = [6:0]
  - rd = [11:7]
  - func3 = [14:12]
  - rs1 = [19:15]
  - rs2 = [24:20]
  - func7 = [31:25]
- Decode:
  - `is_add` = opcode 0110011, func3 000, func7 0000000.
  - `is_sub` = opcode 0110011, func3 000, func7 0100000.
  - Any other encoding is a no-op: no write, no trap.
- Register file:
  - 32 entries of 32 bits.
  - Two asynchronous read ports addressed by rs1 and rs2, plus an asynchronous debug read port.
  - Synchronous write on the rising edge.
- ALU:
  - `alu_result` = rs1_data + rs2_data for ADD, rs1_data − rs2_data for SUB, else 0.
  - Arithmetic is 32-bit modular; carry and overflow are discarded.
- `reg_we` = is_add | is_sub.
- x0 is hardwired to 0: it always reads 0, and writes to it (instruction or debug) are ignored.
- Debug write:
  - Performed on the same edge as the instruction write.
  - If both target the same nonzero register in the same cycle, the debug data wins.
  - If the targets differ, both writes occur.
- Read-during-write: reads return the pre-edge value. There is no bypass.

## Timing
- Reset (asynchronous, immediate):
  - PC = `PC_RESET`.
  - IR = 0 (decodes as a no-op).
  - All registers = 0.
  - `reg_we` = 0 and `alu_result` = 0.
  - Any write pending on the next edge is discarded.
- Cycle sequence after reset deasserts (edge 1 is the first rising edge):
  - Edge 1: IR ← mem[PC_RESET], PC ← PC_RESET+4.
  - Between edges 1 and 2: decode, register read and ALU evaluate combinationally.
  - Edge 2: rd is written; IR ← mem[PC_RESET+4]; PC advances.
- Latency: the writeback for the instruction at address A lands on the second edge after PC = A.
- Throughput: 1 instruction per cycle.
- Back-to-back dependencies need no interlock. The instruction loaded at edge n+1 reads the value written at edge n+1 during the following cycle.
- Reset asserted mid-run takes effect without waiting for an edge. Execution restarts at `PC_RESET` with the cycle sequence above.

## Structure
- Package `addsub_pkg` holds:
  - `OPC_OP` = 7'b0110011
  - `F3_ADDSUB` = 3'b000
  - `F7_ADD` = 7'b0000000
  - `F7_SUB` = 7'b0100000
  - `XLEN` = 32
  - `NREGS` = 32
  - A packed struct for the decoded fields.
- One sub-module, `gpr_file`: 32×32 storage with x0 hardwiring, three asynchronous read ports, instruction write port, debug write port with priority, and asynchronous reset.
- PC, IR, decode and ALU live in the top level.

## Test plan
1. Reset/fetch:
   - Stimulus: assert reset; release; run 3 edges with mem[0]=0x00000013 (not ADD/SUB).
   - Required: PC = 0, 4, 8, 12 on successive edges; IR follows mem; `reg_we` never asserts.
2. ADD:
   - Stimulus: debug-write x1=7, x2=5; mem[0]=0x002081B3 (add x3,x1,x2).
   - Required: `alu_result` = 12 with `reg_we` = 1 in the cycle after edge 1; x3 = 12 after edge 2.
3. SUB and wrap:
   - Stimulus: with x1=7 and x2=5, mem[0]=0x40208233 (sub x4,x1,x2) and mem[4]=0x401102B3 (sub x5,x2,x1).
   - Required: x4 = 2; x5 = 0xFFFFFFFE.
4. Overflow:
   - Stimulus: x1=0xFFFFFFFF, x2=1; mem[0]=add x3,x1,x2.
   - Required: x3 = 0.
5. Non-writes:
   - Stimulus: add x0,x1,x2 (0x00208033), then func7=0000001 (0x022081B3).
   - Required: x0 stays 0; x3 unchanged; `reg_we` = 0 for the second instruction.
6. Mid-run reset and debug collision:
   - Reset stimulus: assert reset between edges with PC = 8.
   - Reset required: PC and all registers read 0 immediately.
   - Collision stimulus: `dbg_we` to x3 (value 99) on the same edge as add x3.
   - Collision required: x3 = 99.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants, decoded-instruction layout and op decode for the ADD/SUB core.
package addsub_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int RIDX_W = $clog2(NREGS);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  typedef struct packed {
    logic [6:0]        func7;
    logic [RIDX_W-1:0] rs2;
    logic [RIDX_W-1:0] rs1;
    logic [2:0]        func3;
    logic [RIDX_W-1:0] rd;
    logic [6:0]        opcode;
  } instr_t;

  typedef enum logic [1:0] {
    ALU_NOP = 2'd0,
    ALU_ADD = 2'd1,
    ALU_SUB = 2'd2
  } alu_op_e;

  // Anything that is not exactly R-type ADD/SUB collapses to a silent no-op.
  function automatic alu_op_e decode_op(input instr_t i);
    alu_op_e op;
    op = ALU_NOP;
    if (i.opcode == OPC_OP && i.func3 == F3_ADDSUB) begin
      if (i.func7 == F7_ADD)      op = ALU_ADD;
      else if (i.func7 == F7_SUB) op = ALU_SUB;
    end
    return op;
  endfunction

endpackage

// File: rtl/addsub_core_if.sv
// Fetch, status and debug-port bundle between the core (master) and its environment (slave).
interface addsub_core_if;
  import addsub_pkg::*;

  logic [XLEN-1:0]   imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  logic [XLEN-1:0]   pc_value;
  logic [XLEN-1:0]   instruction;
  logic              reg_we;
  logic [XLEN-1:0]   alu_result;
  logic              dbg_we;
  logic [RIDX_W-1:0] dbg_addr;
  logic [XLEN-1:0]   dbg_wdata;
  logic [XLEN-1:0]   dbg_rdata;

  modport master (
    output imem_addr, pc_value, instruction, reg_we, alu_result, dbg_rdata,
    input  imem_rdata, dbg_we, dbg_addr, dbg_wdata
  );

  modport slave (
    input  imem_addr, pc_value, instruction, reg_we, alu_result, dbg_rdata,
    output imem_rdata, dbg_we, dbg_addr, dbg_wdata
  );

endinterface

// File: rtl/addsub_core_gpr_file.sv
// 32x32 register file: x0 reads zero, two operand reads plus a debug read, debug write overrides.
module gpr_file
  import addsub_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [RIDX_W-1:0] rs1_addr_i,
  input  logic [RIDX_W-1:0] rs2_addr_i,
  input  logic [RIDX_W-1:0] dbg_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic [XLEN-1:0]   dbg_rdata_o,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] rd_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              dbg_we_i,
  input  logic [XLEN-1:0]   dbg_wdata_i
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

  // Debug write is applied last so it wins a same-register collision.
  always_comb begin
    regs_d = regs_q;
    if (we_i && rd_i != '0)           regs_d[rd_i]       = wdata_i;
    if (dbg_we_i && dbg_addr_i != '0) regs_d[dbg_addr_i] = dbg_wdata_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign rs1_data_o  = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o  = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
  assign dbg_rdata_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/addsub_core.sv
// Single-issue fetch/execute core: PC, IR, ADD/SUB decode and ALU around gpr_file.
module addsub_core
  import addsub_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input logic          clock,
  input logic          reset,
  addsub_core_if.master bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  instr_t          ir;
  alu_op_e         op;
  logic [XLEN-1:0] rs1_data, rs2_data, alu_res;
  logic            wb_en;

  // No stalls or branches: PC strides every edge, IR takes whatever memory returns.
  assign pc_d = pc_q + PC_STEP;
  assign ir_d = bus.imem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= PC_RESET;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign ir = instr_t'(ir_q);
  assign op = decode_op(ir);

  always_comb begin
    alu_res = '0;
    wb_en   = 1'b0;
    case (op)
      ALU_ADD: begin alu_res = rs1_data + rs2_data; wb_en = 1'b1; end
      ALU_SUB: begin alu_res = rs1_data - rs2_data; wb_en = 1'b1; end
      default: begin alu_res = '0;                  wb_en = 1'b0; end
    endcase
  end

  gpr_file u_gpr (
    .clock      (clock),
    .reset      (reset),
    .rs1_addr_i (ir.rs1),
    .rs2_addr_i (ir.rs2),
    .dbg_addr_i (bus.dbg_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .dbg_rdata_o(bus.dbg_rdata),
    .we_i       (wb_en),
    .rd_i       (ir.rd),
    .wdata_i    (alu_res),
    .dbg_we_i   (bus.dbg_we),
    .dbg_wdata_i(bus.dbg_wdata)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.pc_value    = pc_q;
  assign bus.instruction = ir_q;
  assign bus.reg_we      = wb_en;
  assign bus.alu_result  = alu_res;

endmodule

// File: tb/tb_addsub_core.sv
// Directed bench for addsub_core: fetch sequencing, ADD/SUB writeback, x0, collisions, async reset.
module tb_addsub_core;
  import addsub_pkg::*;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADD312  = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] SUB412  = 32'h4020_8233; // sub x4,x1,x2
  localparam logic [31:0] SUB521  = 32'h4011_02B3; // sub x5,x2,x1
  localparam logic [31:0] ADD012  = 32'h0020_8033; // add x0,x1,x2
  localparam logic [31:0] BADF7   = 32'h0220_81B3; // func7=0000001
  localparam logic [31:0] ADD611  = 32'h0010_8333; // add x6,x1,x1

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] mem [0:15];
  int n_chk = 0;
  int n_fail = 0;

  addsub_core_if bus ();
  addsub_core #(.PC_RESET(32'h0), .PC_STEP(32'd4)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  assign bus.imem_rdata = (bus.imem_addr < 32'd64) ? mem[bus.imem_addr[5:2]] : NOP;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle at the falling edge for driving and sampling.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    bus.dbg_addr = a;
    #1;
    v = bus.dbg_rdata;
  endtask

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    bus.dbg_we = 1'b1; bus.dbg_addr = a; bus.dbg_wdata = d;
    tick();
    bus.dbg_we = 1'b0;
  endtask

  task automatic restart();
    @(negedge clock);
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = NOP;

    // Reset state and plain fetch
    @(negedge clock);
    chk("rst_pc", bus.pc_value, 32'h0);
    chk("rst_ir", bus.instruction, 32'h0);
    chk("rst_we", {31'b0, bus.reg_we}, 32'h0);
    chk("rst_alu", bus.alu_result, 32'h0);
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("fetch_pc", bus.pc_value, 32'(4 * e));
      chk("fetch_ir", bus.instruction, NOP);
      chk("fetch_we", {31'b0, bus.reg_we}, 32'h0);
    end

    // ADD, SUB with wrap, x0 target, unknown func7
    restart();
    mem[2] = ADD312; mem[4] = SUB412; mem[5] = SUB521; mem[6] = ADD012; mem[7] = BADF7;
    dbg_wr(5'd1, 32'd7);          // edge 1
    dbg_wr(5'd2, 32'd5);          // edge 2
    tick();                       // edge 3: IR = add x3
    chk("add_ir", bus.instruction, ADD312);
    chk("add_we", {31'b0, bus.reg_we}, 32'h1);
    chk("add_alu", bus.alu_result, 32'd12);
    rd_reg(5'd3, v); chk("add_pre_x3", v, 32'h0);
    tick();                       // edge 4: x3 written
    rd_reg(5'd3, v); chk("add_x3", v, 32'd12);
    tick(); tick();               // edge 6: IR = sub x5, x4 written
    chk("sub5_alu", bus.alu_result, 32'hFFFF_FFFE);
    chk("sub5_we", {31'b0, bus.reg_we}, 32'h1);
    rd_reg(5'd4, v); chk("sub_x4", v, 32'd2);
    tick();                       // edge 7: x5 written, IR = add x0
    rd_reg(5'd5, v); chk("sub_x5", v, 32'hFFFF_FFFE);
    chk("addx0_alu", bus.alu_result, 32'd12);
    tick();                       // edge 8: IR = bad func7
    chk("badf7_we", {31'b0, bus.reg_we}, 32'h0);
    chk("badf7_alu", bus.alu_result, 32'h0);
    tick();
    rd_reg(5'd0, v); chk("x0_zero", v, 32'h0);
    rd_reg(5'd3, v); chk("x3_kept", v, 32'd12);

    // Overflow, debug collisions, debug write to x0
    restart();
    for (int i = 0; i < 16; i++) mem[i] = NOP;
    mem[3] = ADD312; mem[5] = ADD312; mem[6] = ADD611;
    dbg_wr(5'd1, 32'hFFFF_FFFF);  // edge 1
    dbg_wr(5'd2, 32'd1);          // edge 2
    dbg_wr(5'd3, 32'h55);         // edge 3
    rd_reg(5'd3, v); chk("dbg_x3", v, 32'h55);
    tick();                       // edge 4: IR = add x3
    chk("ovf_alu", bus.alu_result, 32'h0);
    tick();                       // edge 5: x3 = 0
    rd_reg(5'd3, v); chk("ovf_x3", v, 32'h0);
    tick();                       // edge 6: IR = add x3 again
    dbg_wr(5'd3, 32'd99);         // edge 7: both target x3
    rd_reg(5'd3, v); chk("coll_x3", v, 32'd99);
    dbg_wr(5'd7, 32'h1234);       // edge 8: add x6 and debug x7
    rd_reg(5'd6, v); chk("both_x6", v, 32'hFFFF_FFFE);
    rd_reg(5'd7, v); chk("both_x7", v, 32'h1234);
    dbg_wr(5'd0, 32'hDEAD);
    rd_reg(5'd0, v); chk("dbg_x0", v, 32'h0);

    // Mid-run asynchronous reset at PC=8
    restart();
    mem[0] = ADD611;
    dbg_wr(5'd1, 32'd3);          // edge 1
    tick();                       // edge 2, x6 = 6
    chk("mid_pc", bus.pc_value, 32'd8);
    rd_reg(5'd6, v); chk("mid_x6", v, 32'd6);
    reset = 1'b1;
    #1;
    chk("arst_pc", bus.pc_value, 32'h0);
    chk("arst_ir", bus.instruction, 32'h0);
    rd_reg(5'd6, v); chk("arst_x6", v, 32'h0);
    rd_reg(5'd1, v); chk("arst_x1", v, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("rerun_pc", bus.pc_value, 32'd4);
    chk("rerun_ir", bus.instruction, ADD611);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
